// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side stream engine.
// Contents:
//   FIFO_WIDTH, FIFO_BUF_DEPTH, FIFO_LEN_W, FIFO_CNT_W : default parameter values
//   PTR_W, OCC_W                                       : holding-buffer pointer/occupancy widths
//   fifo_word_t                                        : one FIFO data word
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH     = 16;
    localparam int unsigned FIFO_BUF_DEPTH = 3;
    localparam int unsigned FIFO_LEN_W     = 8;
    localparam int unsigned FIFO_CNT_W     = 16;

    localparam int unsigned PTR_W = $clog2(FIFO_BUF_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_BUF_DEPTH + 1);

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/stream_holding_buf.sv
// Circular holding buffer with push/pop, occupancy and head-of-queue data.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   push, push_data : write push_data at the tail this clock
//   pop             : retire the head entry this clock
//   occ             : number of valid entries
//   head_data       : oldest entry (stale when occ == 0)
// The owner guarantees no push when full and no pop when empty; a push and a
// pop in the same clock are allowed at any occupancy in between.
module stream_holding_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [WIDTH-1:0]             head_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ_q;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; storage is cleared so head_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    assign occ       = occ_q;
    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine: drains a FIFO pop interface (data one cycle after the
// strobe) into a valid/ready stream with packet framing and a packet counter.
// Ports:
//   clk_core, rst_core           : clock, synchronous active-high reset
//   enable                       : permits issuing new FIFO reads
//   pkt_len                      : beats per packet (0 treated as 1)
//   fifo_empty, fifo_data        : FIFO status and registered read data
//   fifo_read                    : FIFO pop strobe
//   m_valid, m_ready, m_data     : output stream handshake and data
//   m_last                       : final beat of the current packet
//   busy                         : words in flight/buffered or packet partially sent
//   pkt_count                    : completed packets, wrapping
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH,
    parameter int unsigned BUF_DEPTH = FIFO_BUF_DEPTH,
    parameter int unsigned LEN_W     = FIFO_LEN_W,
    parameter int unsigned CNT_W     = FIFO_CNT_W
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             enable,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int unsigned OW    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = OW + 1;

    logic             inflight;
    logic [OW-1:0]    occ;
    logic             pop;
    logic [LEN_W-1:0] bcnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] len_eff;

    // Holding buffer absorbs the FIFO read latency so back-pressure never drops a word.
    stream_holding_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk_core),
        .rst       (rst_core),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    // Only issue a read when its word is guaranteed a free buffer slot.
    assign fifo_read = enable & ~fifo_empty & ~rst_core
                     & ((SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;

    // Length is sampled at the first beat of a packet and held until its last beat.
    assign len_in  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    assign len_eff = (bcnt == '0) ? len_in : len_q;
    assign m_last  = m_valid & (bcnt == len_eff - LEN_W'(1));

    assign busy = inflight | (occ != '0) | (bcnt != '0);

    // Read-latency tracker and framing counters.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            inflight  <= 1'b0;
            bcnt      <= '0;
            len_q     <= '0;
            pkt_count <= '0;
        end else begin
            inflight <= fifo_read;
            if (pop) begin
                if (bcnt == '0) begin
                    len_q <= len_eff;
                end
                if (m_last) begin
                    bcnt      <= '0;
                    pkt_count <= pkt_count + CNT_W'(1);
                end else begin
                    bcnt <= bcnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural FIFO
// whose read data is registered one cycle after the pop strobe.
module tb_fifo_stream_reader;

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic        enable   = 1'b0;
    logic [7:0]  pkt_len  = 8'd4;
    logic        fifo_empty;
    logic [15:0] fifo_data = '0;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready  = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] fmem [0:63];
    int unsigned wr_i = 0;
    int unsigned rd_i = 0;

    always #5 clk_core = ~clk_core;

    fifo_stream_reader dut (
        .clk_core   (clk_core),
        .rst_core   (rst_core),
        .enable     (enable),
        .pkt_len    (pkt_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    // Behavioural FIFO: registered output, pointer never rewound by the reader's reset.
    assign fifo_empty = (rd_i == wr_i);
    always @(posedge clk_core) begin
        if (fifo_read && !fifo_empty) begin
            fifo_data <= fmem[rd_i];
            rd_i      <= rd_i + 1;
        end
    end

    task automatic load(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_i] = base + 16'(i);
            wr_i = wr_i + 1;
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk_core);
        #2;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_core = 1'b1;
        enable   = 1'b0;
        m_ready  = 1'b0;
        next_cycle();
        rst_core = 1'b0;
    endtask

    task automatic test_reset();
        load(16'h0001, 8);
        enable  = 1'b1;
        m_ready = 1'b1;
        pkt_len = 8'd4;
        repeat (2) next_cycle();
        #2;
        total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL reset_fifo_read got=%b want=0", fifo_read); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_data !== 16'h0000) begin bad++; $display("FAIL reset_m_data got=%h want=0000", m_data); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d want=0", pkt_count); end
        next_cycle();
        rst_core = 1'b0;
        enable   = 1'b0;
    endtask

    // Eight preloaded words, pkt_len=4, consumer always ready.
    task automatic test_basic();
        logic exp_rd, exp_v, exp_l;
        logic [15:0] exp_d;
        pkt_len = 8'd4;
        m_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            enable = 1'b1;
            #2;
            exp_rd = (c < 8);
            exp_v  = (c >= 2) && (c <= 9);
            exp_d  = 16'(c - 1);
            exp_l  = (c == 5) || (c == 9);
            total++; if (fifo_read !== exp_rd) begin bad++; $display("FAIL basic_fifo_read c=%0d got=%b want=%b", c, fifo_read, exp_rd); end
            total++; if (m_valid !== exp_v) begin bad++; $display("FAIL basic_m_valid c=%0d got=%b want=%b", c, m_valid, exp_v); end
            total++; if (m_last !== exp_l) begin bad++; $display("FAIL basic_m_last c=%0d got=%b want=%b", c, m_last, exp_l); end
            if (exp_v) begin
                total++; if (m_data !== exp_d) begin bad++; $display("FAIL basic_m_data c=%0d got=%h want=%h", c, m_data, exp_d); end
            end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL basic_pkt_count got=%0d want=2", pkt_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
        enable = 1'b0;
    endtask

    // Six words with m_ready cycling 1,0,0; occupancy tracked by a small reference model.
    task automatic test_backpressure();
        int occ_m, infl_m, nrecv, nread;
        logic exp_rd, exp_v, popm;
        logic [15:0] exp_d;
        do_reset();
        load(16'h0011, 6);
        pkt_len = 8'd6;
        occ_m = 0; infl_m = 0; nrecv = 0; nread = 0;
        for (int i = 0; i < 60 && nrecv < 6; i++) begin
            next_cycle();
            enable  = 1'b1;
            m_ready = (i % 3 == 0);
            #2;
            exp_rd = (nread < 6) && (occ_m + infl_m < 3);
            exp_v  = (occ_m != 0);
            exp_d  = 16'h0011 + 16'(nrecv);
            total++; if (fifo_read !== exp_rd) begin bad++; $display("FAIL bp_fifo_read i=%0d got=%b want=%b", i, fifo_read, exp_rd); end
            total++; if (m_valid !== exp_v) begin bad++; $display("FAIL bp_m_valid i=%0d got=%b want=%b", i, m_valid, exp_v); end
            if (exp_v) begin
                total++; if (m_data !== exp_d) begin bad++; $display("FAIL bp_m_data i=%0d got=%h want=%h", i, m_data, exp_d); end
                total++; if (m_last !== (nrecv == 5)) begin bad++; $display("FAIL bp_m_last i=%0d got=%b want=%b", i, m_last, (nrecv == 5)); end
            end
            popm  = exp_v && m_ready;
            if (popm) nrecv++;
            occ_m  = occ_m + infl_m - (popm ? 1 : 0);
            infl_m = exp_rd ? 1 : 0;
            if (exp_rd) nread++;
        end
        total++; if (nrecv != 6) begin bad++; $display("FAIL bp_timeout got=%0d words want=6", nrecv); end
        next_cycle();
        m_ready = 1'b1;
        #2;
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL bp_pkt_count got=%0d want=1", pkt_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", busy); end
        enable = 1'b0;
    endtask

    // pkt_len=0 behaves as single-beat packets.
    task automatic test_len_zero();
        logic exp_v;
        do_reset();
        load(16'h0021, 3);
        pkt_len = 8'd0;
        m_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            enable = 1'b1;
            #2;
            exp_v = (c >= 2) && (c <= 4);
            total++; if (m_valid !== exp_v) begin bad++; $display("FAIL len0_m_valid c=%0d got=%b want=%b", c, m_valid, exp_v); end
            if (exp_v) begin
                total++; if (m_last !== 1'b1) begin bad++; $display("FAIL len0_m_last c=%0d got=%b want=1", c, m_last); end
                total++; if (m_data !== 16'h0021 + 16'(c - 2)) begin bad++; $display("FAIL len0_m_data c=%0d got=%h want=%h", c, m_data, 16'h0021 + 16'(c - 2)); end
            end
        end
        total++; if (pkt_count !== 16'd3) begin bad++; $display("FAIL len0_pkt_count got=%0d want=3", pkt_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b want=0", busy); end
        enable = 1'b0;
    endtask

    // pkt_len 4 -> 2 after beat 2: current packet still 4 beats, next one 2.
    task automatic test_len_change();
        logic exp_v, exp_l;
        do_reset();
        load(16'h0031, 6);
        pkt_len = 8'd4;
        m_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            enable = 1'b1;
            if (c == 4) pkt_len = 8'd2;
            #2;
            exp_v = (c >= 2) && (c <= 7);
            exp_l = (c == 5) || (c == 7);
            total++; if (m_valid !== exp_v) begin bad++; $display("FAIL lenchg_m_valid c=%0d got=%b want=%b", c, m_valid, exp_v); end
            total++; if (m_last !== exp_l) begin bad++; $display("FAIL lenchg_m_last c=%0d got=%b want=%b", c, m_last, exp_l); end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL lenchg_pkt_count got=%0d want=2", pkt_count); end
        enable = 1'b0;
    endtask

    // enable drops right after one read; that word still arrives, no further reads.
    task automatic test_enable_drop();
        do_reset();
        load(16'h0A01, 5);
        pkt_len = 8'd1;
        m_ready = 1'b1;
        next_cycle();
        enable = 1'b1;
        #2;
        total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL en_first_read got=%b want=1", fifo_read); end
        next_cycle();
        enable = 1'b0;
        #2;
        total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL en_read_off got=%b want=0", fifo_read); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_busy_inflight got=%b want=1", busy); end
        next_cycle();
        #2;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL en_m_valid got=%b want=1", m_valid); end
        total++; if (m_data !== 16'h0A01) begin bad++; $display("FAIL en_m_data got=%h want=0a01", m_data); end
        total++; if (m_last !== 1'b1) begin bad++; $display("FAIL en_m_last got=%b want=1", m_last); end
        for (int c = 3; c <= 5; c++) begin
            next_cycle();
            #2;
            total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL en_no_read c=%0d got=%b want=0", c, fifo_read); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy_clear c=%0d got=%b want=0", c, busy); end
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL en_drained c=%0d got=%b want=0", c, m_valid); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL en_pkt_count got=%0d want=1", pkt_count); end
    endtask

    // Reset with two words buffered and one in flight; FIFO continues at its next word.
    task automatic test_mid_reset();
        m_ready = 1'b0;
        pkt_len = 8'd1;
        for (int c = 0; c <= 2; c++) begin
            next_cycle();
            enable = 1'b1;
            #2;
            total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL mr_fill_read c=%0d got=%b want=1", c, fifo_read); end
        end
        next_cycle();
        rst_core = 1'b1;
        #2;
        total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL mr_read_in_reset got=%b want=0", fifo_read); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mr_pre_valid got=%b want=1", m_valid); end
        total++; if (m_data !== 16'h0A02) begin bad++; $display("FAIL mr_pre_data got=%h want=0a02", m_data); end
        next_cycle();
        rst_core = 1'b0;
        m_ready  = 1'b1;
        #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_m_valid got=%b want=0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b want=0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL mr_pkt_count got=%0d want=0", pkt_count); end
        total++; if (m_data !== 16'h0000) begin bad++; $display("FAIL mr_m_data got=%h want=0000", m_data); end
        total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL mr_resume_read got=%b want=1", fifo_read); end
        next_cycle();
        #2;
        total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL mr_empty_read got=%b want=0", fifo_read); end
        next_cycle();
        #2;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mr_post_valid got=%b want=1", m_valid); end
        total++; if (m_data !== 16'h0A05) begin bad++; $display("FAIL mr_post_data got=%h want=0a05", m_data); end
        next_cycle();
        #2;
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL mr_post_count got=%0d want=1", pkt_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_post_busy got=%b want=0", busy); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_len_change();
        test_enable_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
